// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the round-robin FPU scheduler.
package fpu_sched_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic            add_sub;
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fpu_op_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr+1 and wraps around.
module fpu_rr_arbiter
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    grant_idx_c,
  output logic               grant_any_c
);

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      int unsigned cand;
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!grant_any_c && valid[cand[ID_W-1:0]]) begin
        grant_any_c                  = 1'b1;
        grant_idx_c                  = cand[ID_W-1:0];
        grant_c[cand[ID_W-1:0]]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Round-robin sharing of one combinational FPU adder between NUM_REQ requesters.
// Optional macro FPU_RR_STATS_EN adds saturating op/exception counters.
module fpu_rr_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ-1:0]      i_req_add_sub,
  input  logic [NUM_REQ*FP_W-1:0] i_req_a,
  input  logic [NUM_REQ*FP_W-1:0] i_req_b,
  output logic                    o_fpu_add_sub,
  output logic [FP_W-1:0]         o_fpu_a,
  output logic [FP_W-1:0]         o_fpu_b,
  input  logic [FP_W-1:0]         i_fpu_s,
  input  logic                    i_fpu_ov_flag,
  input  logic                    i_fpu_un_flag,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [FP_W-1:0]         o_rsp_s,
  output logic                    o_rsp_ov_flag,
  output logic                    o_rsp_un_flag
`ifdef FPU_RR_STATS_EN
  ,
  output logic [CNT_W-1:0]        o_op_cnt,
  output logic [CNT_W-1:0]        o_exc_cnt
`endif
);

  sched_state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  fpu_op_t op_q, op_d;
  fpu_op_t req_op [NUM_REQ];

  logic            rsp_valid_d;
  logic [ID_W-1:0] rsp_id_d;
  logic [FP_W-1:0] rsp_s_d;
  logic            rsp_ov_d;
  logic            rsp_un_d;

  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    grant_idx_c;
  logic               grant_any_c;

  fpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid       (i_req_valid),
    .ptr         (ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  // Unpack the flat request buses into per-requester operations.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_op[k].add_sub = i_req_add_sub[k];
      req_op[k].a       = i_req_a[k*FP_W +: FP_W];
      req_op[k].b       = i_req_b[k*FP_W +: FP_W];
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    rsp_valid_d = o_rsp_valid;
    rsp_id_d    = o_rsp_id;
    rsp_s_d     = o_rsp_s;
    rsp_ov_d    = o_rsp_ov_flag;
    rsp_un_d    = o_rsp_un_flag;
    o_req_ready = '0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = grant_c;
        if (grant_any_c) begin
          state_d = S_EXEC;
          ptr_d   = grant_idx_c;
          op_d    = req_op[grant_idx_c];
        end
      end
      S_EXEC: begin
        // ptr_q was loaded with the granted index, so it doubles as the response id.
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = ptr_q;
        rsp_s_d     = i_fpu_s;
        rsp_ov_d    = i_fpu_ov_flag;
        rsp_un_d    = i_fpu_un_flag;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      op_q          <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_id      <= '0;
      o_rsp_s       <= '0;
      o_rsp_ov_flag <= 1'b0;
      o_rsp_un_flag <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      op_q          <= op_d;
      o_rsp_valid   <= rsp_valid_d;
      o_rsp_id      <= rsp_id_d;
      o_rsp_s       <= rsp_s_d;
      o_rsp_ov_flag <= rsp_ov_d;
      o_rsp_un_flag <= rsp_un_d;
    end
  end

  assign o_fpu_add_sub = op_q.add_sub;
  assign o_fpu_a       = op_q.a;
  assign o_fpu_b       = op_q.b;

`ifdef FPU_RR_STATS_EN
  logic rsp_hs_c;
  assign rsp_hs_c = (state_q == S_RESP) && i_rsp_ready;

  // Counters advance on the response handshake and stick at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_op_cnt  <= '0;
      o_exc_cnt <= '0;
    end else if (rsp_hs_c) begin
      o_op_cnt <= sat_inc(o_op_cnt);
      if (o_rsp_ov_flag || o_rsp_un_flag) begin
        o_exc_cnt <= sat_inc(o_exc_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Self-checking bench for fpu_rr_scheduler with a stand-in FPU and a round-robin reference model.
module tb_fpu_rr_scheduler;

  localparam int NR = 4;

  logic          i_clk;
  logic          i_rst_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] req_add_sub;
  logic [NR*32-1:0] req_a;
  logic [NR*32-1:0] req_b;
  logic        fpu_add_sub;
  logic [31:0] fpu_a, fpu_b, fpu_s;
  logic        fpu_ov, fpu_un;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_s;
  logic        rsp_ov, rsp_un;
`ifdef FPU_RR_STATS_EN
  logic [15:0] op_cnt, exc_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fpu_rr_scheduler #(.NUM_REQ(NR)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_add_sub (req_add_sub),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .o_fpu_add_sub (fpu_add_sub),
    .o_fpu_a       (fpu_a),
    .o_fpu_b       (fpu_b),
    .i_fpu_s       (fpu_s),
    .i_fpu_ov_flag (fpu_ov),
    .i_fpu_un_flag (fpu_un),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_id      (rsp_id),
    .o_rsp_s       (rsp_s),
    .o_rsp_ov_flag (rsp_ov),
    .o_rsp_un_flag (rsp_un)
`ifdef FPU_RR_STATS_EN
    ,
    .o_op_cnt      (op_cnt),
    .o_exc_cnt     (exc_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Stand-in FPU: known IEEE results for the directed vectors, an arbitrary mix otherwise.
  function automatic logic [33:0] fpu_model(input logic as, input logic [31:0] a, input logic [31:0] b);
    if (!as && a == 32'h40b00000 && b == 32'h400ccccd) return {2'b00, 32'h40f66666};
    if ( as && a == 32'h3f800000 && b == 32'h3f800000) return {2'b00, 32'h00000000};
    if (!as && a == 32'h7f7fffff && b == 32'h7f7fffff) return {2'b10, 32'h7f800000};
    return {&a[30:27], ~|a[30:27], as ? a - b : a + b};
  endfunction

  always_comb {fpu_ov, fpu_un, fpu_s} = fpu_model(fpu_add_sub, fpu_a, fpu_b);

  // Round-robin choice from the rules: first valid at ptr+1, ptr+2, ... mod NR.
  function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
    for (int i = 1; i <= NR; i++) begin
      if (v[(ptr + i) % NR]) return (ptr + i) % NR;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic as, input logic [31:0] a, input logic [31:0] b);
    req_valid[k]        = 1'b1;
    req_add_sub[k]      = as;
    req_a[k*32 +: 32]   = a;
    req_b[k*32 +: 32]   = b;
  endtask

  task automatic clr_req(input int k);
    req_valid[k] = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n     = 1'b0;
    req_valid   = '0;
    req_add_sub = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b1;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    i_rst_n = 1'b0;
    step();
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_chk++; if ({fpu_add_sub, fpu_a, fpu_b} !== 65'd0) begin n_fail++; $display("FAIL reset_fpu_regs got %h/%h/%h want 0", fpu_add_sub, fpu_a, fpu_b); end
    n_chk++; if ({rsp_id, rsp_s, rsp_ov, rsp_un} !== 36'd0) begin n_fail++; $display("FAIL reset_rsp_regs got %h/%h/%b/%b want 0", rsp_id, rsp_s, rsp_ov, rsp_un); end
    i_rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b0, 32'h40b00000, 32'h400ccccd);
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", req_ready); end
    step();
    clr_req(0);
    #1;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_exec_ready got %b want 0000", req_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec_rsp_valid got %b want 0", rsp_valid); end
    n_chk++; if ({fpu_add_sub, fpu_a, fpu_b} !== {1'b0, 32'h40b00000, 32'h400ccccd}) begin
      n_fail++; $display("FAIL single_fpu_ops got %b/%h/%h want 0/40b00000/400ccccd", fpu_add_sub, fpu_a, fpu_b);
    end
    step();
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency rsp_valid got %b want 1", rsp_valid); end
    n_chk++; if ({rsp_id, rsp_s, rsp_ov, rsp_un} !== {2'd0, 32'h40f66666, 2'b00}) begin
      n_fail++; $display("FAIL single_rsp got id=%0d s=%h ov=%b un=%b want id=0 s=40f66666 ov=0 un=0", rsp_id, rsp_s, rsp_ov, rsp_un);
    end
    step();
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
    n_chk++; if (fpu_a !== 32'h40b00000) begin n_fail++; $display("FAIL single_fpu_hold got %h want 40b00000", fpu_a); end
  endtask

  task automatic test_rr_order();
    int gid[$];
    int gcyc[$];
    do_reset();
    for (int k = 0; k < NR; k++) set_req(k, 1'b0, 32'h40000000 + 32'(k), 32'h40000100);
    for (int cyc = 0; cyc < 40 && gid.size() < 5; cyc++) begin
      #1;
      if (req_ready != '0) begin
        n_chk++; if (!$onehot(req_ready)) begin n_fail++; $display("FAIL rr_onehot got %b want one-hot", req_ready); end
        for (int k = 0; k < NR; k++) if (req_ready[k]) gid.push_back(k);
        gcyc.push_back(cyc);
      end
      step();
    end
    req_valid = '0;
    n_chk++; if (gid.size() != 5) begin n_fail++; $display("FAIL rr_count got %0d want 5 grants", gid.size()); end
    for (int i = 0; i < gid.size(); i++) begin
      n_chk++; if (gid[i] != i % NR) begin n_fail++; $display("FAIL rr_order[%0d] got %0d want %0d", i, gid[i], i % NR); end
      if (i > 0) begin
        n_chk++; if (gcyc[i] - gcyc[i-1] != 3) begin n_fail++; $display("FAIL rr_spacing[%0d] got %0d want 3", i, gcyc[i] - gcyc[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp;
    bit seen = 0;
    do_reset();
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'h41200000, 32'h40400000);
    set_req(2, 1'b0, 32'h40800000, 32'h40800000);
    set_req(3, 1'b0, 32'h40a00000, 32'h40a00000);
    exp = fpu_model(1'b1, 32'h41200000, 32'h40400000);
    #1;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant got %b want 0010", req_ready); end
    step();
    clr_req(1);
    for (int i = 0; i < 5 && !seen; i++) begin
      if (rsp_valid) seen = 1; else step();
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL bp_rsp_timeout got no rsp_valid want 1"); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++; if ({rsp_valid, rsp_id, rsp_ov, rsp_un, rsp_s} !== {1'b1, 2'd1, exp}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b id=%0d ov=%b un=%b s=%h want v=1 id=1 s=%h", i, rsp_valid, rsp_id, rsp_ov, rsp_un, rsp_s, exp[31:0]);
      end
      n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", i, req_ready); end
    end
    rsp_ready = 1'b1;
    step();
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", rsp_valid); end
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant got %b want 0100", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_special();
    int nrsp = 0;
    logic [NR-1:0] acc;
    do_reset();
    set_req(2, 1'b1, 32'h3f800000, 32'h3f800000);
    set_req(1, 1'b0, 32'h7f7fffff, 32'h7f7fffff);
    for (int cyc = 0; cyc < 20 && nrsp < 2; cyc++) begin
      #1;
      acc = req_ready & req_valid;
      if (rsp_valid) begin
        if (nrsp == 0) begin
          n_chk++; if ({rsp_id, rsp_ov, rsp_un, rsp_s} !== {2'd1, 2'b10, 32'h7f800000}) begin
            n_fail++; $display("FAIL ovf_rsp got id=%0d ov=%b un=%b s=%h want id=1 ov=1 un=0 s=7f800000", rsp_id, rsp_ov, rsp_un, rsp_s);
          end
        end else begin
          n_chk++; if ({rsp_id, rsp_ov, rsp_un, rsp_s} !== {2'd2, 2'b00, 32'h0}) begin
            n_fail++; $display("FAIL sub_zero_rsp got id=%0d ov=%b un=%b s=%h want id=2 ov=0 un=0 s=00000000", rsp_id, rsp_ov, rsp_un, rsp_s);
          end
        end
        nrsp++;
      end
      step();
      for (int k = 0; k < NR; k++) if (acc[k]) clr_req(k);
    end
    n_chk++; if (nrsp != 2) begin n_fail++; $display("FAIL special_count got %0d want 2", nrsp); end
  endtask

  task automatic test_reset_mid();
    int nrsp = 0;
    logic [NR-1:0] acc;
    do_reset();
    set_req(3, 1'b0, 32'h41000000, 32'h41000000);
    #1;
    step();
    clr_req(3);
    n_chk++; if (fpu_a !== 32'h41000000) begin n_fail++; $display("FAIL mid_exec_op got %h want 41000000", fpu_a); end
    i_rst_n = 1'b0;
    set_req(0, 1'b0, 32'h40400000, 32'h40400000);
    step();
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
    n_chk++; if (fpu_a !== 32'h0) begin n_fail++; $display("FAIL mid_fpu_clear got %h want 0", fpu_a); end
    i_rst_n = 1'b1;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      acc = req_ready & req_valid;
      if (rsp_valid) begin
        n_chk++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_stale_rsp got id=%0d want 0", rsp_id); end
        nrsp++;
      end
      step();
      for (int k = 0; k < NR; k++) if (acc[k]) clr_req(k);
    end
    n_chk++; if (nrsp != 1) begin n_fail++; $display("FAIL mid_rsp_count got %0d want 1", nrsp); end
  endtask

  task automatic test_random();
    bit m_exec = 0, m_rsp = 0;
    int m_ptr = NR - 1;
    int m_id = 0;
    int g;
    logic [64:0] m_op = '0;
    logic [33:0] m_res = '0;
    logic [NR-1:0] exp_ready;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NR; k++) begin
        if (!req_valid[k] && $urandom_range(0, 2) == 0) set_req(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = (!m_exec && !m_rsp) ? rr_pick(req_valid, m_ptr) : -1;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d got %b want %b", cyc, req_ready, exp_ready); end
      n_chk++; if (rsp_valid !== m_rsp) begin n_fail++; $display("FAIL rnd_rsp_valid@%0d got %b want %b", cyc, rsp_valid, m_rsp); end
      if (m_rsp) begin
        n_chk++; if ({rsp_id, rsp_ov, rsp_un, rsp_s} !== {2'(m_id), m_res}) begin
          n_fail++; $display("FAIL rnd_rsp@%0d got id=%0d ov=%b un=%b s=%h want id=%0d ov=%b un=%b s=%h",
                             cyc, rsp_id, rsp_ov, rsp_un, rsp_s, m_id, m_res[33], m_res[32], m_res[31:0]);
        end
      end
      if (m_exec) begin
        n_chk++; if ({fpu_add_sub, fpu_a, fpu_b} !== m_op) begin n_fail++; $display("FAIL rnd_fpu_ops@%0d got %h want %h", cyc, {fpu_add_sub, fpu_a, fpu_b}, m_op); end
      end
      if (g >= 0) begin
        m_exec = 1; m_id = g; m_ptr = g;
        m_op = {req_add_sub[g], req_a[g*32 +: 32], req_b[g*32 +: 32]};
      end else if (m_exec) begin
        m_exec = 0; m_rsp = 1;
        m_res = fpu_model(m_op[64], m_op[63:32], m_op[31:0]);
      end else if (m_rsp && rsp_ready) begin
        m_rsp = 0;
      end
      step();
      if (g >= 0) clr_req(g);
    end
    req_valid = '0;
  endtask

`ifdef FPU_RR_STATS_EN
  task automatic test_stats();
    do_reset();
    n_chk++; if ({op_cnt, exc_cnt} !== 32'd0) begin n_fail++; $display("FAIL stats_reset got %0d/%0d want 0/0", op_cnt, exc_cnt); end
    for (int j = 0; j < 4; j++) begin
      if (j == 3) set_req(0, 1'b0, 32'h7f7fffff, 32'h7f7fffff);
      else        set_req(0, 1'b0, 32'h40000000 + 32'(j), 32'h40000000);
      step();
      clr_req(0);
      step();
      step();
      step();
    end
    n_chk++; if (op_cnt !== 16'd4) begin n_fail++; $display("FAIL stats_op_cnt got %0d want 4", op_cnt); end
    n_chk++; if (exc_cnt !== 16'd1) begin n_fail++; $display("FAIL stats_exc_cnt got %0d want 1", exc_cnt); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got no completion want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n     = 1'b0;
    req_valid   = '0;
    req_add_sub = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b1;
    test_reset();
    test_single();
    test_rr_order();
    test_backpressure();
    test_special();
    test_reset_mid();
    test_random();
`ifdef FPU_RR_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
